// File: rtl/dual_issue_scheduler.sv
// Purpose : in-order dual-issue stage between fetch and two execute lanes,
//           with a countdown scoreboard and clocked hold buffers for stalled
//           or split instructions.
// Latency : one cycle, fetch pair to registered issue outputs.
// Backpressure: fetch_ready is low while anything is held or during flush.
//           Held instructions retry every cycle until their hazards clear.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   fetch_valid/ready     fetch pair handshake; fetch_instr1 is the older one
//   flush                 synchronous discard of held and fetched instructions
//   issue_instr1/2        registered lane outputs (0x0000 = nop)
//   issue_single          exactly one lane carries an instruction
//   issue_stall           the oldest pending instruction was blocked by a hazard
//
// Optional: define ISSUE_PERF_CNT_EN to add the saturating perf_stall_cnt and
// perf_dual_cnt outputs.
//
// LAT must be in 1..3 because the scoreboard counters are 2 bits wide.

module dual_issue_scheduler #(
  parameter int LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_valid,
  output logic        fetch_ready,
  input  logic [15:0] fetch_instr1,
  input  logic [15:0] fetch_instr2,
  input  logic        flush,
  output logic [15:0] issue_instr1,
  output logic [15:0] issue_instr2,
  output logic        issue_single,
  output logic        issue_stall
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_dual_cnt
`endif
);

  localparam logic [1:0]  S_IDLE  = 2'd0;
  localparam logic [1:0]  S_HOLD1 = 2'd1;
  localparam logic [1:0]  S_HOLD2 = 2'd2;
  localparam logic [1:0]  LAT_V   = 2'(LAT);
  localparam logic [15:0] NOP     = 16'h0000;

  logic [1:0]      state_q, state_d;
  logic [15:0]     hold0_q, hold0_d;
  logic [15:0]     hold1_q, hold1_d;
  logic [15:0]     iss1_q, iss1_d;
  logic [15:0]     iss2_q, iss2_d;
  logic            single_q, single_d;
  logic            stall_q, stall_d;
  logic [7:0][1:0] busy_q, busy_d;

  logic            accept;
  logic [15:0]     c0, c1;
  logic [15:0]     a_instr, b_instr;
  logic            a_vld, b_vld;

  function automatic logic is_nop(input logic [15:0] x);
    return x[15:12] == 4'd0;
  endfunction

  // rs2 is a source only for register-register forms (imm flag clear).
  function automatic logic hazard(input logic [15:0] x, input logic [7:0][1:0] bsy);
    return (bsy[x[7:5]] != 2'd0) || (!x[11] && (bsy[x[4:2]] != 2'd0));
  endfunction

  // Younger instruction reads or rewrites the older one's destination.
  function automatic logic conflict(input logic [15:0] a, input logic [15:0] b);
    return (b[7:5] == a[10:8]) ||
           (!b[11] && (b[4:2] == a[10:8])) ||
           (b[10:8] == a[10:8]);
  endfunction

  assign fetch_ready = (state_q == S_IDLE) && !flush;
  assign accept      = fetch_valid && fetch_ready;

  // Candidate pair in program order; held instructions are always older than
  // anything fetch could offer, which is why fetch is refused while holding.
  always_comb begin
    c0 = NOP;
    c1 = NOP;
    case (state_q)
      S_HOLD2: begin
        c0 = hold0_q;
        c1 = hold1_q;
      end
      S_HOLD1: c0 = hold0_q;
      default: begin
        if (accept) begin
          c0 = fetch_instr1;
          c1 = fetch_instr2;
        end
      end
    endcase
  end

  // Compact away nops so A is the oldest real instruction and B the next.
  assign a_instr = is_nop(c0) ? c1 : c0;
  assign b_instr = is_nop(c0) ? NOP : c1;
  assign a_vld   = !is_nop(a_instr);
  assign b_vld   = !is_nop(b_instr);

  always_comb begin
    state_d  = S_IDLE;
    hold0_d  = NOP;
    hold1_d  = NOP;
    iss1_d   = NOP;
    iss2_d   = NOP;
    single_d = 1'b0;
    stall_d  = 1'b0;
    if (!flush && a_vld) begin
      if (hazard(a_instr, busy_q)) begin
        // B stays behind A even if B itself is ready: strictly in order.
        stall_d = 1'b1;
        hold0_d = a_instr;
        if (b_vld) begin
          hold1_d = b_instr;
          state_d = S_HOLD2;
        end else begin
          state_d = S_HOLD1;
        end
      end else begin
        iss1_d = a_instr;
        if (!b_vld) begin
          single_d = 1'b1;
        end else if (!hazard(b_instr, busy_q) && !conflict(a_instr, b_instr)) begin
          iss2_d = b_instr;
        end else begin
          single_d = 1'b1;
          hold0_d  = b_instr;
          state_d  = S_HOLD1;
        end
      end
    end
  end

  // Counters always age, even across flush, since issued work still
  // completes. A fresh issue reloads its rd, overriding the decrement.
  always_comb begin
    for (int r = 0; r < 8; r++) begin
      busy_d[r] = (busy_q[r] != 2'd0) ? (busy_q[r] - 2'd1) : 2'd0;
    end
    if (!is_nop(iss1_d)) busy_d[iss1_d[10:8]] = LAT_V;
    if (!is_nop(iss2_d)) busy_d[iss2_d[10:8]] = LAT_V;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      hold0_q  <= NOP;
      hold1_q  <= NOP;
      iss1_q   <= NOP;
      iss2_q   <= NOP;
      single_q <= 1'b0;
      stall_q  <= 1'b0;
      busy_q   <= '0;
    end else begin
      state_q  <= state_d;
      hold0_q  <= hold0_d;
      hold1_q  <= hold1_d;
      iss1_q   <= iss1_d;
      iss2_q   <= iss2_d;
      single_q <= single_d;
      stall_q  <= stall_d;
      busy_q   <= busy_d;
    end
  end

  assign issue_instr1 = iss1_q;
  assign issue_instr2 = iss2_q;
  assign issue_single = single_q;
  assign issue_stall  = stall_q;

`ifdef ISSUE_PERF_CNT_EN
  logic [15:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_dual_q, perf_dual_d;

  // Lane 2 only ever carries an instruction when both lanes issue.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_dual_d  = perf_dual_q;
    if (stall_d && (perf_stall_q != 16'hFFFF)) perf_stall_d = perf_stall_q + 16'd1;
    if (!is_nop(iss2_d) && (perf_dual_q != 16'hFFFF)) perf_dual_d = perf_dual_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= 16'd0;
      perf_dual_q  <= 16'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_dual_q  <= perf_dual_d;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_dual_cnt  = perf_dual_q;
`endif

endmodule

// File: tb/tb_dual_issue_scheduler.sv
// Purpose : self-checking bench for dual_issue_scheduler; a queue-based model
//           of pending instructions and per-register busy times is compared
//           against the DUT every cycle, plus directed literal scenarios.
// Latency : inputs change 2 time units after a rising edge, outputs compared
//           on the falling edge.
// Backpressure: fetch_ready expectation comes from the model's pending queue.

module tb_dual_issue_scheduler;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [15:0] fetch_instr1;
  logic [15:0] fetch_instr2;
  logic        flush;
  logic [15:0] issue_instr1;
  logic [15:0] issue_instr2;
  logic        issue_single;
  logic        issue_stall;
`ifdef ISSUE_PERF_CNT_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_dual_cnt;
`endif

  dual_issue_scheduler #(.LAT(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_valid  (fetch_valid),
    .fetch_ready  (fetch_ready),
    .fetch_instr1 (fetch_instr1),
    .fetch_instr2 (fetch_instr2),
    .flush        (flush),
    .issue_instr1 (issue_instr1),
    .issue_instr2 (issue_instr2),
    .issue_single (issue_single),
    .issue_stall  (issue_stall)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_dual_cnt  (perf_dual_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pend holds instructions not yet issued, oldest first.
  logic [15:0] pend[$];
  logic [15:0] cand[$];
  logic [15:0] live[$];
  int          busy[8];
  logic [15:0] e_i1 = 16'h0, e_i2 = 16'h0;
  bit          e_single = 1'b0, e_stall = 1'b0;
  int          n_stall = 0, n_dual = 0;
  logic [15:0] ma, mb;

  function automatic bit m_nop(input logic [15:0] x);
    return x[15:12] == 4'd0;
  endfunction

  function automatic bit m_busy_src(input logic [15:0] x);
    return (busy[x[7:5]] != 0) || (!x[11] && busy[x[4:2]] != 0);
  endfunction

  function automatic bit m_pair_dep(input logic [15:0] a, input logic [15:0] b);
    return (b[7:5] == a[10:8]) || (!b[11] && b[4:2] == a[10:8]) || (b[10:8] == a[10:8]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend = {};
      for (int r = 0; r < 8; r++) busy[r] = 0;
      e_i1 = 16'h0; e_i2 = 16'h0; e_single = 1'b0; e_stall = 1'b0;
      n_stall = 0; n_dual = 0;
    end else begin
      cand = {};
      if (flush) begin
        pend = {};
      end else if (pend.size() != 0) begin
        cand = pend;
      end else if (fetch_valid) begin
        cand = {fetch_instr1, fetch_instr2};
      end
      live = {};
      foreach (cand[i]) if (!m_nop(cand[i])) live.push_back(cand[i]);
      pend = {};
      e_i1 = 16'h0; e_i2 = 16'h0; e_stall = 1'b0;
      if (live.size() > 0) begin
        ma = live[0];
        if (m_busy_src(ma)) begin
          e_stall = 1'b1;
          pend = live;
        end else begin
          e_i1 = ma;
          if (live.size() > 1) begin
            mb = live[1];
            if (!m_busy_src(mb) && !m_pair_dep(ma, mb)) e_i2 = mb;
            else pend.push_back(mb);
          end
        end
      end
      e_single = (e_i1 != 16'h0) != (e_i2 != 16'h0);
      if (e_stall && n_stall < 65535) n_stall++;
      if (e_i2 != 16'h0 && n_dual < 65535) n_dual++;
      for (int r = 0; r < 8; r++) if (busy[r] > 0) busy[r]--;
      if (e_i1 != 16'h0) busy[e_i1[10:8]] = LAT;
      if (e_i2 != 16'h0) busy[e_i2[10:8]] = LAT;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_instr1", issue_instr1, e_i1);
      chk("cyc_instr2", issue_instr2, e_i2);
      chk("cyc_single", issue_single, e_single);
      chk("cyc_stall", issue_stall, e_stall);
      chk("cyc_ready", fetch_ready, (pend.size() == 0) && !flush);
`ifdef ISSUE_PERF_CNT_EN
      chk("cyc_perf_stall", perf_stall_cnt, n_stall);
      chk("cyc_perf_dual", perf_dual_cnt, n_dual);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit v, input logic [15:0] a, input logic [15:0] b, input bit fl);
    fetch_valid  = v;
    fetch_instr1 = a;
    fetch_instr2 = b;
    flush        = fl;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 16'h0, 16'h0, 1'b0);
  endtask

  task automatic lit(input string nm, input logic [15:0] i1, input logic [15:0] i2,
                     input bit s, input bit st);
    chk({nm, "_instr1"}, issue_instr1, i1);
    chk({nm, "_instr2"}, issue_instr2, i2);
    chk({nm, "_single"}, issue_single, s);
    chk({nm, "_stall"}, issue_stall, st);
  endtask

  function automatic logic [15:0] rnd_instr();
    logic [15:0] x;
    x[11:0]  = 12'($urandom);
    x[15:12] = ($urandom_range(0, 4) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    return x;
  endfunction

  initial begin
    rst_n = 1'b0;
    fetch_valid = 1'b0; fetch_instr1 = 16'h0; fetch_instr2 = 16'h0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    lit("reset", 16'h0, 16'h0, 1'b0, 1'b0);
    chk("reset_ready", fetch_ready, 1'b1);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Independent pair issues together; rd 1 and 4 become busy for LAT.
    drive(1'b1, 16'h114C, 16'h24B8, 1'b0);
    lit("indep", 16'h114C, 16'h24B8, 1'b0, 1'b0);
    chk("indep_model_i1", e_i1, 16'h114C);
    chk("indep_busy1", busy[1], 2);
    chk("indep_busy4", busy[4], 2);
    idle(3);

    // Younger reads older's rd: split, two stall cycles, issue at edge 4.
    drive(1'b1, 16'h114C, 16'h2434, 1'b0);
    lit("raw_e1", 16'h114C, 16'h0, 1'b1, 1'b0);
    chk("raw_e1_ready", fetch_ready, 1'b0);
    idle(1);
    lit("raw_e2", 16'h0, 16'h0, 1'b0, 1'b1);
    idle(1);
    lit("raw_e3", 16'h0, 16'h0, 1'b0, 1'b1);
    idle(1);
    lit("raw_e4", 16'h2434, 16'h0, 1'b1, 1'b0);
    chk("raw_e4_ready", fetch_ready, 1'b1);
    idle(3);

    // Leading nop is discarded; survivor moves to lane 1.
    drive(1'b1, 16'h0000, 16'h24B8, 1'b0);
    lit("nopc", 16'h24B8, 16'h0, 1'b1, 1'b0);
    idle(3);

    // Flush while holding 0x2434; scoreboard keeps ageing.
    drive(1'b1, 16'h114C, 16'h2434, 1'b0);
    lit("fl_e1", 16'h114C, 16'h0, 1'b1, 1'b0);
    drive(1'b0, 16'h0, 16'h0, 1'b1);
    lit("fl_e2", 16'h0, 16'h0, 1'b0, 1'b0);
    chk("fl_busy1_a", busy[1], 1);
    chk("fl_ready_low", fetch_ready, 1'b0);
    idle(1);
    lit("fl_e3", 16'h0, 16'h0, 1'b0, 1'b0);
    chk("fl_busy1_b", busy[1], 0);
    chk("fl_ready_high", fetch_ready, 1'b1);
    idle(2);

    // Same rd in both: younger is split off; as a lone held instruction only
    // its sources (r2) are scoreboard-checked, so it goes on the next edge.
    drive(1'b1, 16'h114C, 16'h1148, 1'b0);
    lit("waw_e1", 16'h114C, 16'h0, 1'b1, 1'b0);
    chk("waw_e1_ready", fetch_ready, 1'b0);
    idle(1);
    lit("waw_e2", 16'h1148, 16'h0, 1'b1, 1'b0);
    idle(3);

    // Reach HOLD2 then reset mid-cycle: held pair is dropped.
    drive(1'b1, 16'h114C, 16'h0000, 1'b0);
    lit("h2_pre", 16'h114C, 16'h0, 1'b1, 1'b0);
    drive(1'b1, 16'h2434, 16'h24B8, 1'b0);
    lit("h2_stall", 16'h0, 16'h0, 1'b0, 1'b1);
    chk("h2_ready", fetch_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    lit("rst_mid", 16'h0, 16'h0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    chk("rst_ready", fetch_ready, 1'b1);
    idle(1);
    lit("rst_drop", 16'h0, 16'h0, 1'b0, 1'b0);

    // Randomized traffic against the model, with one mid-run reset.
    for (int k = 0; k < 3000; k++) begin
      drive($urandom_range(0, 9) < 7, rnd_instr(), rnd_instr(), $urandom_range(0, 19) == 0);
      if (k == 1500) begin
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
      end
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
